// File: rtl/rv_pkg.sv
// Shared fetch-path types and constants.
package rv_pkg;
    localparam int unsigned     XLEN             = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = '0;
    localparam logic [31:0]     INSTR_NOP        = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction-memory read port, execute redirect and decode handshake.
interface fetch_stage_if #(
    parameter int unsigned XLEN = rv_pkg::XLEN
);
    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_rdata;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            if_valid;
    logic            if_ready;
    logic [XLEN-1:0] if_instr;
    logic [XLEN-1:0] if_pc;
    logic [XLEN-1:0] if_pc_plus4;
    logic [31:0]     fetch_cnt;

    modport master (
        output imem_addr,
        input  imem_rdata,
        input  redirect_valid,
        input  redirect_pc,
        output if_valid,
        input  if_ready,
        output if_instr,
        output if_pc,
        output if_pc_plus4,
        output fetch_cnt
    );

    modport slave (
        input  imem_addr,
        output imem_rdata,
        output redirect_valid,
        output redirect_pc,
        input  if_valid,
        output if_ready,
        input  if_instr,
        input  if_pc,
        input  if_pc_plus4,
        input  fetch_cnt
    );
endinterface

// File: rtl/fetch_fifo.sv
// Synchronous fetch queue with flush; DEPTH must be a power of two.
module fetch_fifo
    import rv_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  fetch_entry_t             wdata,
    output fetch_entry_t             rdata,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned          AW      = $clog2(DEPTH);
    localparam logic [AW:0]          DEPTH_C = (AW+1)'(DEPTH);

    fetch_entry_t    mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic            full;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, reads instruction memory, queues words for decode.
module fetch_stage
    import rv_pkg::*;
#(
    parameter int unsigned     XLEN     = rv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = rv_pkg::RESET_PC_DEFAULT,
    parameter int unsigned     QDEPTH   = 2
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master bus
);
    localparam int unsigned AW      = $clog2(QDEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(QDEPTH);

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [31:0]     fetch_cnt;
    logic            deq;
    logic            can_enq;
    logic            enq;
    logic            empty;
    logic [AW:0]     count;
    fetch_entry_t    wr_entry;
    fetch_entry_t    head;

    assign pc_plus4 = pc + XLEN'(4);
    assign deq      = bus.if_valid & bus.if_ready;
    assign can_enq  = (count < DEPTH_C) | deq;
    assign enq      = ~bus.redirect_valid & can_enq;
    assign wr_entry = '{pc: pc, pc_plus4: pc_plus4, instr: bus.imem_rdata};

    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= RESET_PC;
            fetch_cnt <= '0;
        end else if (bus.redirect_valid) begin
            pc <= {bus.redirect_pc[XLEN-1:2], 2'b00};
        end else if (enq) begin
            pc        <= pc_plus4;
            fetch_cnt <= fetch_cnt + 32'd1;
        end
    end

    fetch_fifo #(
        .DEPTH(QDEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (bus.redirect_valid),
        .push  (enq),
        .pop   (deq),
        .wdata (wr_entry),
        .rdata (head),
        .empty (empty),
        .count (count)
    );

    // Stale storage behind an empty queue must not leak onto the decode bus.
    assign bus.imem_addr   = pc;
    assign bus.fetch_cnt   = fetch_cnt;
    assign bus.if_valid    = ~empty;
    assign bus.if_instr    = empty ? '0 : head.instr;
    assign bus.if_pc       = empty ? '0 : head.pc;
    assign bus.if_pc_plus4 = empty ? '0 : head.pc_plus4;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; memory model returns 32'h13000000 + address.
module tb_fetch_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    fetch_stage_if #(.XLEN(32)) bus ();
    fetch_stage_if #(.XLEN(32)) bus2 ();

    assign bus.imem_rdata   = 32'h1300_0000 + bus.imem_addr;
    assign bus2.imem_rdata  = 32'h1300_0000 + bus2.imem_addr;
    assign bus2.redirect_valid = 1'b0;
    assign bus2.redirect_pc    = '0;
    assign bus2.if_ready       = 1'b1;

    fetch_stage #(.XLEN(32), .RESET_PC(32'h0), .QDEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    fetch_stage #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC), .QDEPTH(2)) dut_wrap (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        bus.if_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %h want 0", bus.if_valid); end
        checks++; if (bus.if_instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h want 0", bus.if_instr); end
        checks++; if (bus.if_pc !== 32'h0) begin errors++; $display("FAIL reset_if_pc: got %h want 0", bus.if_pc); end
        checks++; if (bus.if_pc_plus4 !== 32'h0) begin errors++; $display("FAIL reset_pc4: got %h want 0", bus.if_pc_plus4); end
        checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", bus.imem_addr); end
        checks++; if (bus.fetch_cnt !== 32'h0) begin errors++; $display("FAIL reset_cnt: got %h want 0", bus.fetch_cnt); end
    endtask

    task automatic test_stream();
        logic [31:0] p;
        do_reset();
        bus.if_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            p = 32'(4 * i);
            checks++; if (bus.if_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d]: got %h want 1", i, bus.if_valid); end
            checks++; if (bus.if_pc !== p) begin errors++; $display("FAIL stream_pc[%0d]: got %h want %h", i, bus.if_pc, p); end
            checks++; if (bus.if_instr !== 32'h1300_0000 + p) begin errors++; $display("FAIL stream_instr[%0d]: got %h want %h", i, bus.if_instr, 32'h1300_0000 + p); end
            checks++; if (bus.fetch_cnt !== 32'(i + 1)) begin errors++; $display("FAIL stream_cnt[%0d]: got %0d want %0d", i, bus.fetch_cnt, i + 1); end
            checks++; if (bus.imem_addr !== p + 32'd4) begin errors++; $display("FAIL stream_addr[%0d]: got %h want %h", i, bus.imem_addr, p + 32'd4); end
        end
    endtask

    task automatic test_stall();
        logic [31:0] p;
        do_reset();
        bus.if_ready = 1'b0;
        step();
        for (int i = 0; i < 5; i++) step();
        checks++; if (bus.fetch_cnt !== 32'd2) begin errors++; $display("FAIL stall_cnt: got %0d want 2", bus.fetch_cnt); end
        checks++; if (bus.imem_addr !== 32'h8) begin errors++; $display("FAIL stall_addr: got %h want 8", bus.imem_addr); end
        checks++; if (bus.if_instr !== 32'h1300_0000) begin errors++; $display("FAIL stall_instr: got %h want 13000000", bus.if_instr); end
        bus.if_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            p = 32'(4 * i);
            checks++; if (bus.if_pc !== p) begin errors++; $display("FAIL release_pc[%0d]: got %h want %h", i, bus.if_pc, p); end
            checks++; if (bus.if_instr !== 32'h1300_0000 + p) begin errors++; $display("FAIL release_instr[%0d]: got %h want %h", i, bus.if_instr, 32'h1300_0000 + p); end
            step();
        end
        checks++; if (bus.if_pc !== 32'hC) begin errors++; $display("FAIL release_next: got %h want c", bus.if_pc); end
    endtask

    task automatic test_redirect();
        do_reset();
        bus.if_ready = 1'b0;
        step();
        step();
        bus.if_ready = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h103;
        checks++; if (bus.if_valid !== 1'b1) begin errors++; $display("FAIL redir_head_valid: got %h want 1", bus.if_valid); end
        step();
        bus.redirect_valid = 1'b0;
        checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL redir_flush: got %h want 0", bus.if_valid); end
        checks++; if (bus.imem_addr !== 32'h100) begin errors++; $display("FAIL redir_addr: got %h want 100", bus.imem_addr); end
        step();
        checks++; if (bus.if_pc !== 32'h100) begin errors++; $display("FAIL redir_if_pc: got %h want 100", bus.if_pc); end
        checks++; if (bus.if_pc_plus4 !== 32'h104) begin errors++; $display("FAIL redir_pc4: got %h want 104", bus.if_pc_plus4); end
        checks++; if (bus.if_instr !== 32'h1300_0100) begin errors++; $display("FAIL redir_instr: got %h want 13000100", bus.if_instr); end
    endtask

    // Runs directly after test_redirect: fetch_cnt is 3 on entry.
    task automatic test_back_to_back();
        bus.if_ready = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h40;
        step();
        bus.redirect_pc = 32'h80;
        checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid1: got %h want 0", bus.if_valid); end
        checks++; if (bus.imem_addr !== 32'h40) begin errors++; $display("FAIL b2b_addr1: got %h want 40", bus.imem_addr); end
        step();
        bus.redirect_valid = 1'b0;
        checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid2: got %h want 0", bus.if_valid); end
        checks++; if (bus.imem_addr !== 32'h80) begin errors++; $display("FAIL b2b_addr2: got %h want 80", bus.imem_addr); end
        checks++; if (bus.fetch_cnt !== 32'd3) begin errors++; $display("FAIL b2b_no_enq: got %0d want 3", bus.fetch_cnt); end
        step();
        checks++; if (bus.if_pc !== 32'h80) begin errors++; $display("FAIL b2b_first_pc: got %h want 80", bus.if_pc); end
        checks++; if (bus.fetch_cnt !== 32'd4) begin errors++; $display("FAIL b2b_cnt: got %0d want 4", bus.fetch_cnt); end
    endtask

    task automatic test_wrap();
        do_reset();
        checks++; if (bus2.imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_reset_addr: got %h want fffffffc", bus2.imem_addr); end
        step();
        checks++; if (bus2.if_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_if_pc: got %h want fffffffc", bus2.if_pc); end
        checks++; if (bus2.if_pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_pc4: got %h want 0", bus2.if_pc_plus4); end
        checks++; if (bus2.if_instr !== 32'h12FF_FFFC) begin errors++; $display("FAIL wrap_instr: got %h want 12fffffc", bus2.if_instr); end
        checks++; if (bus2.imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_next_addr: got %h want 0", bus2.imem_addr); end
        step();
        checks++; if (bus2.if_pc !== 32'h0) begin errors++; $display("FAIL wrap_second_pc: got %h want 0", bus2.if_pc); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        bus.if_ready = 1'b0;
        step();
        step();
        checks++; if (bus.fetch_cnt !== 32'd2) begin errors++; $display("FAIL midrst_pre_cnt: got %0d want 2", bus.fetch_cnt); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %h want 0", bus.if_valid); end
        checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL midrst_addr: got %h want 0", bus.imem_addr); end
        checks++; if (bus.fetch_cnt !== 32'd0) begin errors++; $display("FAIL midrst_cnt: got %0d want 0", bus.fetch_cnt); end
        bus.if_ready = 1'b1;
        step();
        checks++; if (bus.if_pc !== 32'h0) begin errors++; $display("FAIL midrst_refetch_pc: got %h want 0", bus.if_pc); end
        checks++; if (bus.if_instr !== 32'h1300_0000) begin errors++; $display("FAIL midrst_refetch_instr: got %h want 13000000", bus.if_instr); end
        checks++; if (bus.fetch_cnt !== 32'd1) begin errors++; $display("FAIL midrst_refetch_cnt: got %0d want 1", bus.fetch_cnt); end
    endtask

    initial begin
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        bus.if_ready = 1'b0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_back_to_back();
        test_wrap();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
